// File: rtl/vga_pic_buf_if.sv
// Bus between the Sobel/VGA side and the frame store.
//
// Handshake semantics: there is no ready and no backpressure. pi_flag is a
// valid-only strobe; pi_data is consumed on every rising vga_clk edge where
// pi_flag=1. A pixel request is the pair (pix_x, pix_y) sampled on every edge
// (10'h3FF in either coordinate means "no request"). Its answer appears on
// pix_data exactly one cycle later. frame_done is a one-cycle pulse.
// disp_en exposes the display state (0 = EMPTY, 1 = SHOWING) for debug.
interface vga_pic_buf_if;
    logic       pi_flag;
    logic [7:0] pi_data;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic [7:0] pix_data;
    logic       frame_done;
    logic       disp_en;

    modport master (
        output pi_flag, pi_data, pix_x, pix_y,
        input  pix_data, frame_done, disp_en
    );

    modport slave (
        input  pi_flag, pi_data, pix_x, pix_y,
        output pix_data, frame_done, disp_en
    );
endinterface

// File: rtl/vga_pic_buf.sv
// Frame store between the Sobel edge engine and the VGA timing controller.
// Writes the raster byte stream into on-chip RAM and serves a centred
// IMG_W x IMG_H window to the controller with one cycle of read latency.
module vga_pic_buf #(
    parameter int         IMG_W    = 100,
    parameter int         IMG_H    = 100,
    parameter int         X0       = 270,
    parameter int         Y0       = 190,
    parameter int         ADDR_W   = 14,
    parameter logic [7:0] BG_COLOR = 8'h00
) (
    input  logic          vga_clk,
    input  logic          sys_rst_n,
    vga_pic_buf_if.slave  bus
);

    localparam int              DEPTH     = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ROW_LEN   = ADDR_W'(IMG_W);
    localparam logic [9:0]      X_LO      = 10'(X0);
    localparam logic [9:0]      X_HI      = 10'(X0 + IMG_W - 1);
    localparam logic [9:0]      Y_LO      = 10'(Y0);
    localparam logic [9:0]      Y_HI      = 10'(Y0 + IMG_H - 1);
    localparam logic [9:0]      NO_REQ    = 10'h3FF;

    // EMPTY until the first complete frame lands; only reset goes back.
    typedef enum logic {
        EMPTY   = 1'b0,
        SHOWING = 1'b1
    } disp_state_t;

    disp_state_t       state_q, state_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              frame_done_q, frame_done_d;
    logic              wrap;

    logic              in_win;
    logic              in_win_r;
    logic [ADDR_W-1:0] dx, dy;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        ram_q;

    logic [7:0]        mem [0:DEPTH-1];

    assign wrap = bus.pi_flag && (wr_addr_q == LAST_ADDR);

    // Write pointer, frame pulse and display-state next values.
    always_comb begin
        state_d      = state_q;
        wr_addr_d    = wr_addr_q;
        frame_done_d = 1'b0;
        if (bus.pi_flag) begin
            if (wrap) begin
                wr_addr_d    = '0;
                frame_done_d = 1'b1;
                state_d      = SHOWING;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end
    end

    // Control registers; RAM contents deliberately survive reset.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= EMPTY;
            wr_addr_q    <= '0;
            frame_done_q <= 1'b0;
            in_win_r     <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_addr_q    <= wr_addr_d;
            frame_done_q <= frame_done_d;
            in_win_r     <= in_win && (state_q == SHOWING);
        end
    end

    // Window hit test and linear read address; address held at 0 outside
    // the window so the RAM is never indexed past its depth.
    always_comb begin
        in_win = (bus.pix_x != NO_REQ) && (bus.pix_y != NO_REQ) &&
                 (bus.pix_x >= X_LO) && (bus.pix_x <= X_HI) &&
                 (bus.pix_y >= Y_LO) && (bus.pix_y <= Y_HI);
        dx      = ADDR_W'(bus.pix_x - X_LO);
        dy      = ADDR_W'(bus.pix_y - Y_LO);
        rd_addr = '0;
        if (in_win) begin
            rd_addr = dy * ROW_LEN + dx;
        end
    end

    // Single-clock RAM, read-first: a same-cycle read of the written
    // address returns the byte stored before this write.
    always_ff @(posedge vga_clk) begin
        if (bus.pi_flag) begin
            mem[wr_addr_q] <= bus.pi_data;
        end
        ram_q <= mem[rd_addr];
    end

    assign bus.pix_data   = in_win_r ? ram_q : BG_COLOR;
    assign bus.frame_done = frame_done_q;
    assign bus.disp_en    = (state_q == SHOWING);

endmodule

// File: tb/tb_vga_pic_buf.sv
// Randomised scoreboard bench for vga_pic_buf.
module tb_vga_pic_buf;

    localparam int         IMG_W = 100;
    localparam int         IMG_H = 100;
    localparam int         X0    = 270;
    localparam int         Y0    = 190;
    localparam int         DEPTH = IMG_W * IMG_H;
    localparam logic [7:0] BG    = 8'h00;

    logic vga_clk;
    logic sys_rst_n;

    vga_pic_buf_if bus ();

    vga_pic_buf #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .X0       (X0),
        .Y0       (Y0),
        .ADDR_W   (14),
        .BG_COLOR (BG)
    ) dut (
        .vga_clk   (vga_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    // ---------------- reference model ----------------
    logic [7:0] model_mem [DEPTH];
    int         wr_count;
    bit         showing;
    int         frames_exp;

    // ---------------- scoreboard ----------------
    // entry = {disp_en, frame_done, pix_data} expected one cycle after issue
    logic [9:0] exp_q[$];
    int n_cmp;
    int n_fail;
    int fd_seen;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge vga_clk);
        sys_rst_n   = 1'b0;
        bus.pi_flag = 1'b0;
        bus.pi_data = 8'h00;
        bus.pix_x   = 10'h3FF;
        bus.pix_y   = 10'h3FF;
        #1;
        check("reset_pix_data", 32'(bus.pix_data), 32'(BG));
        check("reset_frame_done", 32'(bus.frame_done), 32'd0);
        check("reset_disp_en", 32'(bus.disp_en), 32'd0);
        repeat (2) @(negedge vga_clk);
        sys_rst_n = 1'b1;
        wr_count  = 0;
        showing   = 1'b0;
    endtask

    // One clock of stimulus; expectation comes from the model state before
    // this cycle's write (read-first RAM, display state as of this cycle).
    task automatic step(input bit flag, input logic [7:0] data, input int x, input int y);
        logic [7:0] exp_pix;
        bit         exp_fd;
        int         dx;
        int         dy;
        @(negedge vga_clk);
        bus.pi_flag = flag;
        bus.pi_data = data;
        bus.pix_x   = 10'(x);
        bus.pix_y   = 10'(y);
        dx = x - X0;
        dy = y - Y0;
        exp_pix = BG;
        if (showing && dx >= 0 && dx < IMG_W && dy >= 0 && dy < IMG_H)
            exp_pix = model_mem[dy * IMG_W + dx];
        exp_fd = 1'b0;
        if (flag) begin
            model_mem[wr_count] = data;
            if (wr_count == DEPTH - 1) begin
                wr_count = 0;
                exp_fd   = 1'b1;
                showing  = 1'b1;
                frames_exp++;
            end else begin
                wr_count++;
            end
        end
        exp_q.push_back({showing, exp_fd, exp_pix});
    endtask

    task automatic rand_req(output int x, output int y);
        if ($urandom_range(0, 15) == 0) begin
            x = 10'h3FF;
            y = $urandom_range(0, 3) == 0 ? 10'h3FF : $urandom_range(180, 300);
        end else begin
            x = $urandom_range(260, 380);
            y = $urandom_range(180, 300);
        end
    endtask

    task automatic write_frame_bytes(input int n, input bit use_index);
        int x;
        int y;
        for (int i = 0; i < n; i++) begin
            rand_req(x, y);
            step($urandom_range(0, 7) != 0 || use_index ? 1'b1 : 1'b0,
                 use_index ? 8'(i) : 8'($urandom_range(0, 255)), x, y);
            if (!use_index && bus.pi_flag == 1'b0) i--;
        end
    endtask

    // ---------------- monitor ----------------
    always @(posedge vga_clk) begin
        logic [9:0] e;
        #1;
        if (bus.frame_done) fd_seen++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("pix_data", 32'(bus.pix_data), 32'(e[7:0]));
            check("frame_done", 32'(bus.frame_done), 32'(e[8]));
            check("disp_en", 32'(bus.disp_en), 32'(e[9]));
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int x;
        int y;
        logic [7:0] new_b;
        n_cmp = 0; n_fail = 0; fd_seen = 0; frames_exp = 0;
        wr_count = 0; showing = 1'b0;
        sys_rst_n = 1'b1;
        bus.pi_flag = 1'b0; bus.pi_data = 8'h00;
        bus.pix_x = 10'h3FF; bus.pix_y = 10'h3FF;

        // reset state and empty-store read
        do_reset();
        step(1'b0, 8'h00, 270, 190);

        // full frame, value = index[7:0]
        write_frame_bytes(DEPTH, 1'b1);
        step(1'b0, 8'h00, 270, 190);
        step(1'b0, 8'h00, 271, 190);
        step(1'b0, 8'h00, 369, 289);
        step(1'b0, 8'h00, 269, 190);
        step(1'b0, 8'h00, 370, 190);
        step(1'b0, 8'h00, 270, 290);
        step(1'b0, 8'h00, 270, 189);
        step(1'b0, 8'h00, 10'h3FF, 10'h3FF);
        step(1'b0, 8'h00, 10'h3FF, 190);
        step(1'b0, 8'h00, 270, 10'h3FF);
        for (int i = 0; i < 200; i++) begin
            rand_req(x, y);
            step(1'b0, 8'h00, x, y);
        end

        // reset, half frame stays hidden, completed frame shows byte 0
        do_reset();
        write_frame_bytes(DEPTH / 2, 1'b0);
        step(1'b0, 8'h00, 270, 190);
        write_frame_bytes(DEPTH / 2, 1'b0);
        step(1'b0, 8'h00, 270, 190);

        // reset mid-frame, then a full frame from address 0
        do_reset();
        write_frame_bytes(3000, 1'b0);
        do_reset();
        write_frame_bytes(DEPTH, 1'b0);

        // same-cycle write and read of address 0: old byte, then new byte
        new_b = ~model_mem[0];
        step(1'b1, new_b, 270, 190);
        step(1'b0, 8'h00, 270, 190);
        step(1'b0, 8'h00, 10'h3FF, 10'h3FF);

        repeat (3) @(negedge vga_clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("frame_done_pulses", 32'(fd_seen), 32'(frames_exp));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
